// File: rtl/senha_pkg.sv
// Shared types and widths for the keypad code controller (controlador_senha).
package senha_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        EVAL   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam int IDX_W      = 2;
    localparam int TRIES_W    = 2;
    localparam int LOCK_CNT_W = 16;
    localparam int TO_CNT_W   = 16;

    // Digit i of the stored code lives at code[4i+3:4i]; digit 0 is entered first.
    function automatic logic [3:0] code_digit(input logic [15:0] code,
                                              input logic [IDX_W-1:0] idx);
        return code[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/comparador_4bits.sv
// Single 4-bit equality comparator shared by all digit positions of the code entry.
module comparador_4bits (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic       eq_o
);

    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/controlador_senha.sv
// Keypad code controller: arms/disarms on a correct code, latches intrusion alarm, locks out after repeated failures.
// Optional feature: define SENHA_TIMEOUT_EN to discard a partial entry after TIMEOUT_CYCLES idle cycles.
module controlador_senha
    import senha_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCK_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        key_clear,
    input  logic [15:0] code,
    input  logic        sensor,
    output logic        armed,
    output logic        alarm,
    output logic        locked,
    output logic        code_ok,
    output logic        fail,
    output logic [1:0]  tries_left
);

    if (N_DIGITS < 1 || N_DIGITS > 4 || MAX_TRIES < 1 || MAX_TRIES > 3 ||
        LOCK_CYCLES < 1 || LOCK_CYCLES > (2 ** LOCK_CNT_W) ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** TO_CNT_W)) begin : g_param_check
        $error("controlador_senha: parameter out of range");
    end

    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(N_DIGITS - 1);
    localparam logic [TRIES_W-1:0]    TRIES_INIT = TRIES_W'(MAX_TRIES);
    localparam logic [LOCK_CNT_W-1:0] LOCK_LAST  = LOCK_CNT_W'(LOCK_CYCLES - 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  mism_q, mism_d;
    logic                  armed_q, armed_d;
    logic                  alarm_q, alarm_d;
    logic                  ok_q, ok_d;
    logic                  fail_q, fail_d;
    logic [TRIES_W-1:0]    tries_q, tries_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic                  digit_eq;
    logic                  timeout_hit;

    comparador_4bits u_cmp (
        .a_i  (key_digit),
        .b_i  (code_digit(code, idx_q)),
        .eq_o (digit_eq)
    );

`ifdef SENHA_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;

    // Counts consecutive keyless cycles in ENTRY; any key or leaving ENTRY restarts it.
    always_comb begin
        to_cnt_d    = '0;
        timeout_hit = 1'b0;
        if (state_q == ENTRY && !key_valid && !key_clear) begin
            if (to_cnt_q == TO_LAST) timeout_hit = 1'b1;
            else                     to_cnt_d    = to_cnt_q + TO_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mism_d     = mism_q;
        armed_d    = armed_q;
        alarm_d    = alarm_q;
        ok_d       = 1'b0;
        fail_d     = 1'b0;
        tries_d    = tries_q;
        lock_cnt_d = '0;

        if (armed_q && sensor) alarm_d = 1'b1;

        unique case (state_q)
            IDLE, ENTRY: begin
                if (key_clear || timeout_hit) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    mism_d  = 1'b0;
                end else if (key_valid) begin
                    mism_d = mism_q | ~digit_eq;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = EVAL;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ENTRY;
                    end
                end
            end
            EVAL: begin
                state_d = IDLE;
                idx_d   = '0;
                mism_d  = 1'b0;
                if (!mism_q) begin
                    ok_d    = 1'b1;
                    armed_d = ~armed_q;
                    // Disarming clears the alarm even if the sensor fires on this same edge.
                    if (armed_q) alarm_d = 1'b0;
                    tries_d = TRIES_INIT;
                end else begin
                    fail_d  = 1'b1;
                    tries_d = tries_q - TRIES_W'(1);
                    if (tries_q == TRIES_W'(1)) state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (lock_cnt_q == LOCK_LAST) begin
                    state_d = IDLE;
                    tries_d = TRIES_INIT;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            mism_q     <= 1'b0;
            armed_q    <= 1'b0;
            alarm_q    <= 1'b0;
            ok_q       <= 1'b0;
            fail_q     <= 1'b0;
            tries_q    <= TRIES_INIT;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mism_q     <= mism_d;
            armed_q    <= armed_d;
            alarm_q    <= alarm_d;
            ok_q       <= ok_d;
            fail_q     <= fail_d;
            tries_q    <= tries_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign armed      = armed_q;
    assign alarm      = alarm_q;
    assign locked     = (state_q == LOCKED);
    assign code_ok    = ok_q;
    assign fail       = fail_q;
    assign tries_left = tries_q;

endmodule

// File: tb/tb_controlador_senha.sv
// Directed bench for controlador_senha with default parameters (code 4321 entered as 1,2,3,4).
module tb_controlador_senha;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        key_clear;
    logic [15:0] code;
    logic        sensor;
    logic        armed;
    logic        alarm;
    logic        locked;
    logic        code_ok;
    logic        fail;
    logic [1:0]  tries_left;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    controlador_senha dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .key_clear  (key_clear),
        .code       (code),
        .sensor     (sensor),
        .armed      (armed),
        .alarm      (alarm),
        .locked     (locked),
        .code_ok    (code_ok),
        .fail       (fail),
        .tries_left (tries_left)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic enter4(input logic [3:0] d0, input logic [3:0] d1,
                          input logic [3:0] d2, input logic [3:0] d3);
        press(d0);
        press(d1);
        press(d2);
        press(d3);
    endtask

    // Checks the pulse is absent during EVAL, present for one cycle after, then gone.
    task automatic result(input string tag, input logic exp_ok, input logic exp_fail,
                          input logic [1:0] exp_tries, input logic exp_armed);
        check({tag, ".eval_ok"}, code_ok, 1'b0);
        check({tag, ".eval_fail"}, fail, 1'b0);
        tick();
        check({tag, ".ok"}, code_ok, exp_ok);
        check({tag, ".fail"}, fail, exp_fail);
        check({tag, ".tries"}, tries_left, exp_tries);
        check({tag, ".armed"}, armed, exp_armed);
        tick();
        check({tag, ".ok_end"}, code_ok, 1'b0);
        check({tag, ".fail_end"}, fail, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_digit = 4'h0;
        key_clear = 1'b0;
        sensor    = 1'b0;
        code      = 16'h4321;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst.armed", armed, 1'b0);
        check("rst.alarm", alarm, 1'b0);
        check("rst.locked", locked, 1'b0);
        check("rst.ok", code_ok, 1'b0);
        check("rst.fail", fail, 1'b0);
        check("rst.tries", tries_left, 2'd3);

        // Correct code arms the system.
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        result("arm", 1'b1, 1'b0, 2'd3, 1'b1);

        // Sensor while armed latches alarm; disarm clears it even with sensor still high.
        sensor = 1'b1;
        tick();
        sensor = 1'b0;
        check("alarm.set", alarm, 1'b1);
        repeat (3) tick();
        check("alarm.hold", alarm, 1'b1);
        sensor = 1'b1;
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        check("alarm.pre_disarm", alarm, 1'b1);
        result("disarm", 1'b1, 1'b0, 2'd3, 1'b0);
        check("alarm.cleared", alarm, 1'b0);
        tick();
        check("alarm.no_rearm", alarm, 1'b0);
        sensor = 1'b0;

        // key_clear beats a simultaneous key and discards the partial entry.
        press(4'd1);
        press(4'd2);
        key_clear = 1'b1;
        key_valid = 1'b1;
        key_digit = 4'd3;
        tick();
        key_clear = 1'b0;
        key_valid = 1'b0;
        check("clear.fail", fail, 1'b0);
        tick();
        check("clear.fail2", fail, 1'b0);
        check("clear.tries", tries_left, 2'd3);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        result("after_clear", 1'b1, 1'b0, 2'd3, 1'b1);

        // Three wrong codes lead to lockout; alarm keeps latching meanwhile.
        sensor = 1'b1;
        tick();
        sensor = 1'b0;
        check("lock.alarm_set", alarm, 1'b1);
        enter4(4'd5, 4'd5, 4'd5, 4'd5);
        result("wrong1", 1'b0, 1'b1, 2'd2, 1'b1);
        enter4(4'd5, 4'd5, 4'd5, 4'd5);
        result("wrong2", 1'b0, 1'b1, 2'd1, 1'b1);
        enter4(4'd5, 4'd5, 4'd5, 4'd5);
        check("wrong3.eval_fail", fail, 1'b0);
        tick();
        check("wrong3.fail", fail, 1'b1);
        check("wrong3.tries", tries_left, 2'd0);
        check("wrong3.locked", locked, 1'b1);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        check("lock.ignore_ok", code_ok, 1'b0);
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        check("lock.ignore_ok2", code_ok, 1'b0);
        check("lock.armed", armed, 1'b1);
        repeat (994) tick();
        check("lock.last_cycle", locked, 1'b1);
        check("lock.last_tries", tries_left, 2'd0);
        check("lock.alarm_held", alarm, 1'b1);
        tick();
        check("lock.released", locked, 1'b0);
        check("lock.reload", tries_left, 2'd3);

        // One wrong digit in the middle still fails the whole code.
        enter4(4'd1, 4'd2, 4'd9, 4'd4);
        result("mid_wrong", 1'b0, 1'b1, 2'd2, 1'b1);
        check("mid_wrong.alarm", alarm, 1'b1);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        result("recover", 1'b1, 1'b0, 2'd3, 1'b0);
        check("recover.alarm", alarm, 1'b0);

`ifdef SENHA_TIMEOUT_EN
        press(4'd1);
        press(4'd2);
        repeat (500) tick();
        enter4(4'd3, 4'd4, 4'd1, 4'd2);
        result("timeout", 1'b0, 1'b1, 2'd2, 1'b0);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        result("timeout_rearm", 1'b1, 1'b0, 2'd3, 1'b1);
`else
        press(4'd1);
        press(4'd2);
        repeat (600) tick();
        press(4'd3);
        press(4'd4);
        result("no_timeout", 1'b1, 1'b0, 2'd3, 1'b1);
`endif

        // Asynchronous reset while locked with alarm set.
        sensor = 1'b1;
        tick();
        sensor = 1'b0;
        enter4(4'd5, 4'd5, 4'd5, 4'd5);
        result("rl_wrong1", 1'b0, 1'b1, 2'd2, 1'b1);
        enter4(4'd5, 4'd5, 4'd5, 4'd5);
        result("rl_wrong2", 1'b0, 1'b1, 2'd1, 1'b1);
        enter4(4'd5, 4'd5, 4'd5, 4'd5);
        tick();
        repeat (10) tick();
        check("rl.pre_locked", locked, 1'b1);
        check("rl.pre_alarm", alarm, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rl.armed", armed, 1'b0);
        check("rl.alarm", alarm, 1'b0);
        check("rl.locked", locked, 1'b0);
        check("rl.tries", tries_left, 2'd3);
        check("rl.ok", code_ok, 1'b0);
        check("rl.fail", fail, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rl.after_locked", locked, 1'b0);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        result("rl.rearm", 1'b1, 1'b0, 2'd3, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
